// File: rtl/alarm_button_pio_in_pkg.sv
// alarm_button_pio_in_pkg: register map shared by the button PIO and its partners
package alarm_button_pio_in_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
endpackage

// File: rtl/alarm_button_pio_in_debounce_bit.sv
// pio_debounce_bit: one button - polarity fix, 2-flop sync, debounce, press pulse
module pio_debounce_bit
  import alarm_button_pio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s0, s1, done;
  logic [CW-1:0] cnt;
  assign done = (s1 != stable) && (cnt == LAST);
  assign press = done && s1;
  // bring the raw pin into the clk domain as a 1 = pressed level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {s1, s0} <= 2'b00;
    else begin
      s0 <= pin ^ ACTIVE_LOW;
      s1 <= s0;
    end
  // accept the synced level only after it has differed for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stable <= 1'b0;
      cnt <= '0;
    end else begin
      stable <= done ? s1 : stable;
      cnt <= (s1 == stable || done) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/alarm_button_pio_in.sv
// alarm_button_pio_in: Avalon-MM button input port with debounce, press capture and irq
module alarm_button_pio_in
  import alarm_button_pio_in_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] stable, press, mask_q, edge_q, clr;
  logic wr, unused_wd;
  assign unused_wd = ^writedata;
  assign wr = chipselect && !write_n;
  assign clr = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_db (
      .clk(clk), .reset_n(reset_n), .pin(in_port[i]), .stable(stable[i]), .press(press[i]));
  end
  // mask writes, sticky press capture (set beats clear), registered irq
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mask_q <= '0;
      edge_q <= '0;
      irq <= 1'b0;
    end else begin
      mask_q <= (wr && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
      edge_q <= (edge_q & ~clr) | press;
      irq <= |(edge_q & mask_q);
    end
  // zero-latency read mux
  always_comb
    readdata = address == ADDR_DATA ? 32'(stable) :
               address == ADDR_MASK ? 32'(mask_q) :
               address == ADDR_EDGE ? 32'(edge_q) : 32'h0;
endmodule

// File: tb/tb_alarm_button_pio_in.sv
// tb_alarm_button_pio_in: vector table, directed corner sequences and random run vs a history-based model
module tb_alarm_button_pio_in;
  localparam int DEB = 4;
  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1, irq;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = 32'h0, readdata;
  logic [3:0] in_port = 4'h0;
  int checks = 0, fails = 0;

  alarm_button_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq));

  always #5 clk = ~clk;

  // reference model: pressed-level history per edge, a button is accepted once its
  // synchroniser output has shown the opposite level for the last DEB edges since the last change
  logic [3:0] m_stable = 4'h0, m_mask = 4'h0, m_edge = 4'h0;
  logic m_irq = 1'b0;
  logic [3:0] pin_q[$], syn_q[$];
  int since[4] = '{default: 0};

  function automatic logic [3:0] flips();
    logic [3:0] f = 4'h0;
    int n = syn_q.size();
    for (int i = 0; i < 4; i++)
      if (since[i] + 1 >= DEB) begin
        f[i] = 1'b1;
        for (int j = 1; j <= DEB; j++) if (syn_q[n-j][i] == m_stable[i]) f[i] = 1'b0;
      end
    return f;
  endfunction

  function automatic logic [3:0] w1c();
    return (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    return a == 2'd0 ? {28'h0, m_stable} : a == 2'd2 ? {28'h0, m_mask} :
           a == 2'd3 ? {28'h0, m_edge} : 32'h0;
  endfunction

  always @(posedge clk)
    if (!reset_n) begin
      pin_q.delete();
      syn_q.delete();
      m_stable <= 4'h0;
      m_mask <= 4'h0;
      m_edge <= 4'h0;
      m_irq <= 1'b0;
      for (int i = 0; i < 4; i++) since[i] <= 0;
    end else begin
      pin_q.push_back(~in_port);
      syn_q.push_back(pin_q.size() >= 3 ? pin_q[pin_q.size()-3] : 4'h0);
      m_stable <= m_stable ^ flips();
      m_edge <= (m_edge & ~w1c()) | (flips() & ~m_stable);
      m_mask <= (chipselect && !write_n && address == 2'd2) ? writedata[3:0] : m_mask;
      m_irq <= |(m_edge & m_mask);
      for (int i = 0; i < 4; i++) since[i] <= ((flips() >> i) & 4'h1) != 0 ? 0 : since[i] + 1;
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rd(input string n, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(n, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] a;
    logic cs;
    logic wn;
    logic [31:0] wd;
    logic [31:0] rd;
    logic irq;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{2'd1, 1'b1, 1'b1, 32'h0,         32'h0, 1'b0};
    tbl[1]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[2]  = '{2'd2, 1'b1, 1'b1, 32'h0,         32'hF, 1'b0};
    tbl[3]  = '{2'd2, 1'b0, 1'b0, 32'h0,         32'hF, 1'b0};
    tbl[4]  = '{2'd2, 1'b1, 1'b1, 32'h0,         32'hF, 1'b0};
    tbl[5]  = '{2'd0, 1'b1, 1'b1, 32'h0,         32'h0, 1'b0};
    tbl[6]  = '{2'd3, 1'b1, 1'b1, 32'h0,         32'h0, 1'b0};
    tbl[7]  = '{2'd0, 1'b1, 1'b0, 32'hF,         32'h0, 1'b0};
    tbl[8]  = '{2'd0, 1'b1, 1'b1, 32'h0,         32'h0, 1'b0};
    tbl[9]  = '{2'd2, 1'b1, 1'b0, 32'h5,         32'hF, 1'b0};
    tbl[10] = '{2'd2, 1'b1, 1'b1, 32'h0,         32'h5, 1'b0};
    tbl[11] = '{2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[12] = '{2'd2, 1'b1, 1'b0, 32'h0,         32'h5, 1'b0};
    tbl[13] = '{2'd2, 1'b1, 1'b1, 32'h0,         32'h0, 1'b0};
    @(negedge clk);
    cyc();
    // reset with all buttons held
    chk_rd("rst_data", 2'd0, 32'h0);
    chk_rd("rst_edge", 2'd3, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    repeat (5) cyc();
    chk_rd("held_data_early", 2'd0, 32'h0);
    cyc();
    chk_rd("held_data", 2'd0, 32'hF);
    chk_rd("held_edge", 2'd3, 32'hF);
    repeat (3) cyc();
    chk("held_irq", {31'h0, irq}, 32'h0);
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    repeat (10) cyc();
    chk_rd("release_data", 2'd0, 32'h0);
    chk_rd("release_edge", 2'd3, 32'h0);
    // register access vectors
    for (int i = 0; i < 14; i++) begin
      address = tbl[i].a;
      chipselect = tbl[i].cs;
      write_n = tbl[i].wn;
      writedata = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].rd);
      chk($sformatf("tbl%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].irq});
      cyc();
    end
    chipselect = 1'b0;
    write_n = 1'b1;
    // bounce on bit 0 ending pressed
    for (int k = 0; k < 8; k++) begin
      in_port[0] = (k % 2 == 0);
      if (k < 7) cyc();
    end
    repeat (5) cyc();
    chk_rd("bounce_data_early", 2'd0, 32'h0);
    cyc();
    chk_rd("bounce_data", 2'd0, 32'h1);
    chk_rd("bounce_edge", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    repeat (8) cyc();
    chk_rd("bounce_edge_once", 2'd3, 32'h0);
    in_port = 4'hF;
    repeat (10) cyc();
    chk_rd("bounce_release", 2'd0, 32'h0);
    // irq only from masked bit
    wr(2'd2, 32'h2);
    in_port = 4'b1110;
    repeat (8) cyc();
    chk_rd("irq_b0_edge", 2'd3, 32'h1);
    chk("irq_b0_irq", {31'h0, irq}, 32'h0);
    in_port = 4'b1100;
    repeat (5) cyc();
    chk_rd("irq_b1_edge_early", 2'd3, 32'h1);
    cyc();
    chk_rd("irq_b1_edge", 2'd3, 32'h3);
    chk("irq_b1_irq_early", {31'h0, irq}, 32'h0);
    cyc();
    chk("irq_b1_irq", {31'h0, irq}, 32'h1);
    // write-one-to-clear
    wr(2'd3, 32'h1);
    chk_rd("w1c_b0", 2'd3, 32'h2);
    chk("w1c_b0_irq", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h0);
    chk_rd("w1c_zero", 2'd3, 32'h2);
    wr(2'd3, 32'h2);
    chk_rd("w1c_b1", 2'd3, 32'h0);
    chk("w1c_b1_irq_lag", {31'h0, irq}, 32'h1);
    cyc();
    chk("w1c_b1_irq", {31'h0, irq}, 32'h0);
    // clear and press on the same edge
    in_port = 4'b1000;
    repeat (5) cyc();
    wr(2'd3, 32'h4);
    chk_rd("collide_edge", 2'd3, 32'h4);
    chk_rd("collide_data", 2'd0, 32'h7);
    cyc();
    chk("collide_irq", {31'h0, irq}, 32'h0);
    // random traffic against the model, with a reset in the middle
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      chk("rand_irq", {31'h0, irq}, {31'h0, m_irq});
      chk("rand_rd", readdata, model_rd(address));
      if (c == 700) reset_n = 1'b0;
      if (c == 702) reset_n = 1'b1;
      if ($urandom_range(0, 7) == 0) in_port = 4'($urandom);
      address = 2'($urandom);
      chipselect = 1'($urandom);
      write_n = $urandom_range(0, 3) != 0;
      writedata = $urandom;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
